// File: rtl/s2c_call_arb.sv
// s2c_call_arb: serialises round-robin channel calls and periodic end-check polls onto one tagged bridge port.
// Each call is tracked by tag; unanswered calls are aborted after TIMEOUT cycles in WAIT.
module s2c_call_arb #(
    parameter int NUM_CH            = 4,
    parameter int DATA_WORDS        = 8,
    parameter int TIMEOUT           = 1024,
    parameter int END_POLL_INTERVAL = 256,
    parameter int TAG_W             = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CH-1:0]                req_valid,
    output logic [NUM_CH-1:0]                req_ready,
    input  logic [NUM_CH-1:0]                req_dir,
    input  logic [NUM_CH*32-1:0]             req_id,
    input  logic [NUM_CH*32-1:0]             req_fn,
    input  logic [NUM_CH*DATA_WORDS*32-1:0]  req_data,
    output logic [NUM_CH-1:0]                rsp_valid,
    input  logic [NUM_CH-1:0]                rsp_ready,
    output logic [31:0]                      rsp_ret,
    output logic [DATA_WORDS*32-1:0]         rsp_data,
    output logic                             call_valid,
    input  logic                             call_ready,
    output logic [31:0]                      call_id,
    output logic [31:0]                      call_fn,
    output logic                             call_dir,
    output logic [TAG_W-1:0]                 call_tag,
    output logic [DATA_WORDS*32-1:0]         call_data,
    input  logic                             done_valid,
    input  logic [TAG_W-1:0]                 done_tag,
    input  logic [31:0]                      done_ret,
    input  logic [DATA_WORDS*32-1:0]         done_data,
    output logic                             sim_end,
    output logic                             timeout_err,
    output logic                             busy
);
    localparam int DW = DATA_WORDS * 32;
    localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int PW = END_POLL_INTERVAL > 1 ? $clog2(END_POLL_INTERVAL) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            r_state;
    logic              r_src_poll, r_poll_pending, r_sim_end, r_timeout_err, r_call_dir;
    logic [CW-1:0]     r_src, r_rr_ptr, w_gnt_idx, w_k;
    logic [TAG_W-1:0]  r_tag, r_wait_tag;
    logic [TW-1:0]     r_timer;
    logic [PW-1:0]     r_poll_cnt;
    logic [31:0]       r_call_id, r_call_fn, r_rsp_ret;
    logic [DW-1:0]     r_call_data, r_rsp_data;
    logic              w_gnt_any, w_grant, w_done_hit, w_poll_wrap;

    // Scan from the farthest offset down so the channel nearest rr_ptr wins.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_k       = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            w_k = CW'((int'(r_rr_ptr) + i) % NUM_CH);
            if (req_valid[w_k]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_k;
            end
        end
    end

    assign w_grant     = r_state == IDLE && !r_poll_pending && !r_sim_end && w_gnt_any;
    assign w_done_hit  = done_valid && done_tag == r_wait_tag;
    assign w_poll_wrap = END_POLL_INTERVAL > 0 && r_poll_cnt == PW'(END_POLL_INTERVAL - 1);

    assign req_ready   = w_grant ? (NUM_CH'(1) << w_gnt_idx) : '0;
    assign rsp_valid   = r_state == RESP ? (NUM_CH'(1) << r_src) : '0;
    assign call_valid  = r_state == ISSUE;
    assign busy        = r_state != IDLE;
    assign call_tag    = r_tag;
    assign call_id     = r_call_id;
    assign call_fn     = r_call_fn;
    assign call_dir    = r_call_dir;
    assign call_data   = r_call_data;
    assign rsp_ret     = r_rsp_ret;
    assign rsp_data    = r_rsp_data;
    assign sim_end     = r_sim_end;
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_src_poll     <= 1'b0;
            r_poll_pending <= 1'b0;
            r_sim_end      <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_call_dir     <= 1'b0;
            r_src          <= '0;
            r_rr_ptr       <= '0;
            r_tag          <= '0;
            r_wait_tag     <= '0;
            r_timer        <= '0;
            r_poll_cnt     <= '0;
            r_call_id      <= '0;
            r_call_fn      <= '0;
            r_rsp_ret      <= '0;
            r_call_data    <= '0;
            r_rsp_data     <= '0;
        end else begin
            if (END_POLL_INTERVAL > 0)
                r_poll_cnt <= w_poll_wrap ? '0 : r_poll_cnt + 1'b1;
            case (r_state)
                IDLE: begin
                    if (r_poll_pending) begin
                        r_call_id      <= '0;
                        r_call_fn      <= 32'd2;
                        r_call_dir     <= 1'b0;
                        r_call_data    <= '0;
                        r_src_poll     <= 1'b1;
                        r_poll_pending <= 1'b0;
                        r_state        <= ISSUE;
                    end else if (w_grant) begin
                        r_call_id   <= req_id[int'(w_gnt_idx)*32 +: 32];
                        r_call_fn   <= req_fn[int'(w_gnt_idx)*32 +: 32];
                        r_call_dir  <= req_dir[w_gnt_idx];
                        r_call_data <= req_dir[w_gnt_idx] ? req_data[int'(w_gnt_idx)*DW +: DW] : '0;
                        r_src       <= w_gnt_idx;
                        r_src_poll  <= 1'b0;
                        r_rr_ptr    <= w_gnt_idx == CW'(NUM_CH - 1) ? '0 : w_gnt_idx + 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (call_ready) begin
                        r_wait_tag <= r_tag;
                        r_tag      <= r_tag + 1'b1;
                        r_timer    <= '0;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_done_hit || r_timer == TW'(TIMEOUT)) begin
                        r_rsp_ret     <= w_done_hit ? done_ret : '1;
                        r_rsp_data    <= w_done_hit ? done_data : '0;
                        r_timeout_err <= r_timeout_err | !w_done_hit;
                        r_sim_end     <= r_sim_end | (w_done_hit && r_src_poll && done_ret != 32'd0);
                        r_state       <= r_src_poll ? IDLE : RESP;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready[r_src])
                        r_state <= IDLE;
                end
            endcase
            // A wrap in the same cycle as a poll launch re-arms the next poll.
            if (w_poll_wrap)
                r_poll_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_s2c_call_arb.sv
// tb_s2c_call_arb: directed and random channel/poll traffic against a transaction-level model of the arbiter.
module tb_s2c_call_arb;
    localparam int NC  = 4;
    localparam int DWD = 8;
    localparam int DW  = DWD * 32;
    localparam int TO  = 16;
    localparam int EPI = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NC-1:0]     req_valid = '0, req_ready, req_dir = '0, rsp_valid, rsp_ready = '0;
    logic [NC*32-1:0]  req_id = '0, req_fn = '0;
    logic [NC*DW-1:0]  req_data = '0;
    logic [31:0]       rsp_ret, call_id, call_fn, done_ret = '0;
    logic [DW-1:0]     rsp_data, call_data, done_data = '0;
    logic              call_valid, call_ready = 1'b0, call_dir, done_valid = 1'b0;
    logic [3:0]        call_tag, done_tag = '0;
    logic              sim_end, timeout_err, busy;

    s2c_call_arb #(.NUM_CH(NC), .DATA_WORDS(DWD), .TIMEOUT(TO), .END_POLL_INTERVAL(EPI), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
        .req_id(req_id), .req_fn(req_fn), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ret(rsp_ret), .rsp_data(rsp_data),
        .call_valid(call_valid), .call_ready(call_ready), .call_id(call_id), .call_fn(call_fn),
        .call_dir(call_dir), .call_tag(call_tag), .call_data(call_data),
        .done_valid(done_valid), .done_tag(done_tag), .done_ret(done_ret), .done_data(done_data),
        .sim_end(sim_end), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_err = 0;
    int          m_cyc, m_tag, m_rr;
    bit          m_pend, m_send, m_terr;
    logic [31:0] poll_ret;
    logic [31:0] ch_id [NC];
    logic [31:0] ch_fn [NC];
    logic        ch_dir [NC];
    logic [DW-1:0] ch_data [NC];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The poll counter runs from reset release; a poll becomes pending every EPI-th edge.
    task automatic tick(input bit consume);
        @(posedge clk);
        m_cyc++;
        if (consume) m_pend = 1'b0;
        if (m_cyc % EPI == 0) m_pend = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] r;
        for (int w = 0; w < DWD; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic rnd_chans();
        for (int c = 0; c < NC; c++) begin
            ch_id[c]   = $urandom;
            ch_fn[c]   = $urandom;
            ch_dir[c]  = 1'($urandom_range(0, 1));
            ch_data[c] = rnd_data();
        end
    endtask

    task automatic drive_req(input logic [NC-1:0] vmask);
        for (int c = 0; c < NC; c++) begin
            req_id[c*32 +: 32] = ch_id[c];
            req_fn[c*32 +: 32] = ch_fn[c];
            req_dir[c]         = ch_dir[c];
            req_data[c*DW +: DW] = ch_data[c];
        end
        req_valid = vmask;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0; rsp_ready = '0; call_ready = 1'b0; done_valid = 1'b0;
        #1;
        chk("rst_call_valid", call_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sim_end", sim_end, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_call_tag", call_tag, 0);
        chk("rst_call_id", call_id, 0);
        chk("rst_call_data", call_data, 0);
        chk("rst_rsp_ret", rsp_ret, 0);
        chk("rst_rsp_data", rsp_data, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_cyc = 0; m_pend = 0; m_tag = 0; m_rr = 0; m_send = 0; m_terr = 0;
    endtask

    task automatic poll_call();
        int itag;
        #1;
        chk("poll_blocks_req_ready", req_ready, 0);
        tick(1'b1);
        chk("poll_call_valid", call_valid, 1);
        chk("poll_call_id", call_id, 0);
        chk("poll_call_fn", call_fn, 2);
        chk("poll_call_dir", call_dir, 0);
        chk("poll_call_data", call_data, 0);
        chk("poll_call_tag", call_tag, m_tag);
        call_ready = 1'b1;
        tick(1'b0);
        call_ready = 1'b0;
        itag = m_tag;
        m_tag = (m_tag + 1) % 16;
        chk("poll_wait_call_valid", call_valid, 0);
        done_valid = 1'b1; done_tag = 4'(itag); done_ret = poll_ret; done_data = rnd_data();
        tick(1'b0);
        done_valid = 1'b0;
        if (poll_ret != 0) m_send = 1'b1;
        chk("poll_no_rsp", rsp_valid, 0);
        chk("poll_back_idle", busy, 0);
        chk("poll_sim_end", sim_end, m_send);
    endtask

    // lat < 0 leaves the bridge silent so the call times out.
    task automatic chan_call(input logic [NC-1:0] vmask, input int lat, input logic [31:0] ret, input logic [DW-1:0] rdata);
        int g, itag;
        logic [NC-1:0] onehot;
        drive_req(vmask);
        while (m_pend) poll_call();
        g = m_rr;
        while (!vmask[g]) g = (g + 1) % NC;
        onehot = NC'(1 << g);
        #1;
        chk("req_ready_grant", req_ready, onehot);
        tick(1'b0);
        m_rr = (g + 1) % NC;
        chk("req_ready_one_cycle", req_ready, 0);
        req_valid = vmask & ~onehot;
        chk("call_valid", call_valid, 1);
        chk("call_id", call_id, ch_id[g]);
        chk("call_fn", call_fn, ch_fn[g]);
        chk("call_dir", call_dir, ch_dir[g]);
        chk("call_data", call_data, ch_dir[g] ? ch_data[g] : '0);
        chk("call_tag", call_tag, m_tag);
        repeat ($urandom_range(0, 2)) begin
            tick(1'b0);
            chk("issue_hold", call_valid, 1);
        end
        call_ready = 1'b1;
        tick(1'b0);
        call_ready = 1'b0;
        itag = m_tag;
        m_tag = (m_tag + 1) % 16;
        chk("wait_call_valid", call_valid, 0);
        if (lat >= 0) begin
            for (int i = 0; i < lat; i++) begin
                if (i == 0) begin
                    done_valid = 1'b1; done_tag = 4'(itag ^ 1); done_ret = $urandom; done_data = rnd_data();
                end
                tick(1'b0);
                done_valid = 1'b0;
                chk("wait_no_rsp", rsp_valid, 0);
            end
            done_valid = 1'b1; done_tag = 4'(itag); done_ret = ret; done_data = rdata;
            tick(1'b0);
            done_valid = 1'b0;
            chk("rsp_valid", rsp_valid, onehot);
            chk("rsp_ret", rsp_ret, ret);
            chk("rsp_data", rsp_data, rdata);
        end else begin
            for (int i = 0; i <= TO; i++) begin
                chk("timeout_not_yet", rsp_valid, 0);
                tick(1'b0);
            end
            m_terr = 1'b1;
            chk("timeout_rsp_valid", rsp_valid, onehot);
            chk("timeout_rsp_ret", rsp_ret, 32'hFFFF_FFFF);
            chk("timeout_rsp_data", rsp_data, 0);
        end
        chk("timeout_err", timeout_err, m_terr);
        repeat ($urandom_range(0, 2)) begin
            rsp_ready = ~onehot;
            tick(1'b0);
            chk("rsp_hold", rsp_valid, onehot);
        end
        rsp_ready = onehot;
        tick(1'b0);
        rsp_ready = '0;
        req_valid = '0;
        chk("rsp_released", rsp_valid, 0);
        chk("idle_after_rsp", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        poll_ret = 0;
        #2;
        do_reset();

        // single pull on ch1
        rnd_chans();
        ch_id[1] = 5; ch_fn[1] = 3; ch_dir[1] = 1'b0;
        d = '0;
        d[31:0] = 32'hA5A5;
        chan_call(4'b0010, 3, 32'd0, d);

        // all channels valid: fair rotation and incrementing tags
        do_reset();
        for (int n = 0; n < 5; n++) begin
            rnd_chans();
            chan_call(4'hF, 0, $urandom, rnd_data());
        end

        // silent bridge on a push, stale completion, then a normal call
        do_reset();
        rnd_chans();
        ch_dir[2] = 1'b1;
        chan_call(4'b0100, -1, 32'd0, '0);
        done_valid = 1'b1; done_tag = 4'd0; done_ret = $urandom; done_data = rnd_data();
        tick(1'b0);
        done_valid = 1'b0;
        chk("stale_done_no_rsp", rsp_valid, 0);
        chk("stale_done_idle", busy, 0);
        rnd_chans();
        chan_call(4'b0100, 2, $urandom, rnd_data());

        // periodic polls; nonzero return ends the simulation and blocks grants
        do_reset();
        for (int i = 0; i < 40 && !m_pend; i++) begin
            chk("pre_poll_idle", busy, 0);
            tick(1'b0);
        end
        poll_call();
        for (int i = 0; i < 40 && !m_pend; i++) begin
            chk("between_polls_idle", busy, 0);
            tick(1'b0);
        end
        poll_ret = 32'd1;
        poll_call();
        poll_ret = 32'd0;
        rnd_chans();
        drive_req(4'hF);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("ended_no_ready", req_ready, 0);
            chk("ended_idle", busy, 0);
            tick(1'b0);
        end
        req_valid = '0;

        // grant coincides with poll becoming pending, then poll beats ch0
        do_reset();
        while (m_cyc < EPI - 1) tick(1'b0);
        rnd_chans();
        chan_call(4'b0001, 1, $urandom, rnd_data());
        rnd_chans();
        chan_call(4'b0001, 2, $urandom, rnd_data());

        // reset in the middle of a WAIT
        do_reset();
        rnd_chans();
        chan_call(4'b1000, -1, 32'd0, '0);
        rnd_chans();
        drive_req(4'b0001);
        tick(1'b0);
        req_valid = '0;
        call_ready = 1'b1;
        tick(1'b0);
        call_ready = 1'b0;
        tick(1'b0);
        chk("mid_wait_busy", busy, 1);
        do_reset();
        done_valid = 1'b1; done_tag = 4'd1; done_ret = $urandom; done_data = rnd_data();
        tick(1'b0);
        done_valid = 1'b0;
        chk("post_rst_stale_no_rsp", rsp_valid, 0);
        rnd_chans();
        chan_call(4'b0001, 2, $urandom, rnd_data());

        // random traffic with background polling
        do_reset();
        for (int n = 0; n < 40; n++) begin
            rnd_chans();
            chan_call(NC'($urandom_range(1, 15)), ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 10)),
                      $urandom, rnd_data());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/s2c_call_arb.md
# s2c_call_arb

Multi-channel, parametrised arbiter/sequencer for sim-to-C function calls. Collects pull (data request) and push (monitor) calls from up to NUM_CH clocked agents via valid/ready handshakes. Serialises them onto a single call port toward the DPI bridge, tracks each call with a tag, and applies a timeout. Periodically injects the end-check call (id=0, fn=2) and raises a sticky end flag, so testbench agents never invoke the bridge directly.

## Interface

- NUM_CH, 4, number of requesting channels (≥1)
- DATA_WORDS, 8, 32-bit payload words per call (matches S2CIF_DATA_SIZE)
- TIMEOUT, 1024, max cycles in WAIT before a call is aborted (≥1)
- END_POLL_INTERVAL, 256, cycles between end-check calls; 0 disables polling
- TAG_W, 4, call tag width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_CH  per-channel call request
- req_ready  out  NUM_CH  per-channel accept (one-hot, one cycle)
- req_dir  in  NUM_CH  0=pull, 1=push
- req_id, req_fn  in  NUM_CH*32 each  call id / function number
- req_data  in  NUM_CH*DATA_WORDS*32  push payload (ignored for pull)
- rsp_valid  out  NUM_CH  response available to channel
- rsp_ready  in  NUM_CH  channel accepts response
- rsp_ret  out  32  return code (shared bus; qualified by rsp_valid)
- rsp_data  out  DATA_WORDS*32  returned data
- call_valid  out  1  call presented to bridge
- call_ready  in  1  bridge accepts call
- call_id, call_fn  out  32 each; call_dir out 1; call_tag out TAG_W; call_data out DATA_WORDS*32
- done_valid  in  1  bridge completion pulse (no backpressure)
- done_tag  in  TAG_W; done_ret in 32; done_data in DATA_WORDS*32
- sim_end  out  1  sticky: end-check returned nonzero
- timeout_err  out  1  sticky: at least one call timed out
- busy  out  1  state ≠ IDLE

## Operation

- States: IDLE, ISSUE, WAIT, RESP. Call source is a registered flag: channel index or POLL.
- IDLE, if poll_pending: load id=0, fn=2, dir=0, data=0, source=POLL; clear poll_pending; go to ISSUE. POLL takes priority over channels.
- IDLE, otherwise if !sim_end and any req_valid: round-robin grant starting at rr_ptr. Assert req_ready[g] that cycle and capture id/fn/dir/data; pull captures data as 0. Set rr_ptr=g+1 mod NUM_CH; go to ISSUE.
- After sim_end, no further grants; pending channel requests stay unacknowledged.
- ISSUE: call_valid=1 with stable payload and call_tag=tag. On call_ready, tag increments (wraps mod 2^TAG_W), timer clears, go to WAIT.
- WAIT: timer increments each cycle.
  - done_valid with done_tag == issued tag: latch ret/data. Source POLL sets sim_end if ret≠0 and returns to IDLE. Source channel goes to RESP.
  - done_valid with mismatched tag (late completion of an aborted call) is ignored.
  - Timer reaches TIMEOUT: latch ret=32'hFFFF_FFFF, data=0, set timeout_err. POLL returns to IDLE; channel goes to RESP.
- done_valid in IDLE, ISSUE or RESP is ignored.
- RESP: rsp_valid[src]=1 with rsp_ret/rsp_data held. On rsp_ready[src], go to IDLE.
- Poll counter: when END_POLL_INTERVAL>0, increments every cycle. At END_POLL_INTERVAL-1 it sets poll_pending and wraps to 0. Setting while pending has no further effect.

## Timing

- Reset values: state IDLE, all outputs 0, rr_ptr 0, tag 0, poll counter 0, poll_pending 0, sim_end 0, timeout_err 0.
- Reset mid-call aborts the call without a response. A done_valid arriving after reset with the old tag is ignored unless the tag value coincides.
- req_ready is combinational from state/req_valid/rr_ptr/poll_pending, and only asserts in IDLE.
- Grant at cycle 0 → call_valid at cycle 1. call_ready at cycle 1 → WAIT from cycle 2.
- done_valid at cycle k → rsp_valid at k+1. rsp handshake at cycle m → IDLE at m+1; next grant possible at m+1.
- Minimum channel call occupancy is 4 cycles (grant, issue, done, resp).
- Timeout: the call aborts on the cycle the WAIT timer equals TIMEOUT; the response appears the next cycle.
- A grant cycle and a poll_pending set in the same cycle: the grant wins, and the poll is issued at the next IDLE.

## Test plan

- Single pull on ch1 (id=5, fn=3), bridge answers ret=0, data[0]=0xA5A5 three cycles later → call_id=5, call_dir=0, call_data=0; rsp_valid[1] with rsp_ret=0, rsp_data[0]=0xA5A5; req_ready[1] one cycle.
- All 4 channels valid continuously, bridge answers immediately → grant order 0,1,2,3,0; no channel starves; tags 0,1,2,3,4.
- Push on ch2, bridge silent, TIMEOUT=16 → abort 16 cycles into WAIT; rsp_ret=0xFFFFFFFF, rsp_data=0, timeout_err=1. A later done with the stale tag is ignored, and the next call completes normally.
- END_POLL_INTERVAL=32, poll answered ret=0 then ret=1 → call_id=0, call_fn=2 roughly every 32 cycles; no rsp_valid to any channel; sim_end rises after the second poll; subsequent req_valid never gets req_ready.
- Poll pending while ch0 request arrives in IDLE → poll issued first, ch0 granted at the following IDLE.
- rst asserted during WAIT → all outputs 0 immediately, tag 0, sim_end/timeout_err cleared; a fresh call after release completes.
